// File: rtl/bcd_conv_arb.sv
// ============================================================================
// Module   : bcd_conv_arb
// Purpose  : Two-requester arbiter sharing one multi-cycle 16-bit binary to
//            5-digit BCD converter (double dabble, 16 shift cycles).
// Options  : define BCD_BLANK_EN to register a leading-zero blank mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_arb #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] bin0,
  input  logic [15:0] bin1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic [18:0] bcd,
  output logic        done,
  output logic        done_id,
  output logic [4:0]  blank
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [34:0] work_q, work_d, work_adj;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        gnt0_q, gnt1_q, done_q, done_id_q;
  logic [18:0] bcd_q;
  logic        w_any_req, w_start, w_win;

  // w_win is the index of the requester that wins this cycle
  generate
    if (FIXED_PRIO != 0) begin : g_fixed
      assign w_win = ~req0;
    end else begin : g_rr
      assign w_win = (req0 & req1) ? ~last_q : ~req0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_any_req) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == 4'd15) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_any_req = req0 | req1;
    w_start   = (state_q == S_IDLE) && w_any_req;
    busy      = (state_q != S_IDLE);
  end

  // Add-3 correction on every digit field, then a left shift
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[16+4*i +: 4] > 4'd4)
        work_adj[16+4*i +: 4] = work_q[16+4*i +: 4] + 4'd3;
    end
    if (work_q[34:32] > 3'd4)
      work_adj[34:32] = work_q[34:32] + 3'd3;

    work_d = work_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    id_d   = id_q;
    if (w_start) begin
      work_d = {19'd0, (w_win ? bin1 : bin0)};
      cnt_d  = 4'd0;
      last_d = w_win;
      id_d   = w_win;
    end else if (state_q == S_SHIFT) begin
      work_d = work_adj << 1;
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q    <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      bcd_q     <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      id_q   <= id_d;
      gnt0_q <= w_start & ~w_win;
      gnt1_q <= w_start & w_win;
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        bcd_q     <= work_q[34:16];
        done_id_q <= id_q;
      end
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd     = bcd_q;

`ifdef BCD_BLANK_EN
  logic [4:0] blank_q, blank_d;

  // A digit blanks only when it and every higher digit are zero
  always_comb begin
    blank_d    = '0;
    blank_d[4] = (work_q[34:32] == 3'd0);
    blank_d[3] = blank_d[4] && (work_q[31:28] == 4'd0);
    blank_d[2] = blank_d[3] && (work_q[27:24] == 4'd0);
    blank_d[1] = blank_d[2] && (work_q[23:20] == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (state_q == S_DONE) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 5'b00000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arb.sv
// ============================================================================
// Module   : tb_bcd_conv_arb
// Purpose  : Directed self-checking bench for bcd_conv_arb (round-robin and
//            fixed-priority instances); blank checks follow BCD_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_conv_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] bin0, bin1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [18:0] bcd;
  logic [4:0]  blank;

  logic        f_req0, f_req1;
  logic [15:0] f_bin0, f_bin1;
  logic        f_gnt0, f_gnt1, f_busy, f_done, f_done_id;
  logic [18:0] f_bcd;
  logic [4:0]  f_blank;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_conv_arb #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .bin0(bin0), .bin1(bin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .bcd(bcd),
    .done(done), .done_id(done_id), .blank(blank)
  );

  bcd_conv_arb #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .req1(f_req1), .bin0(f_bin0), .bin1(f_bin1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .busy(f_busy), .bcd(f_bcd),
    .done(f_done), .done_id(f_done_id), .blank(f_blank)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_blank(input string tag, input logic [4:0] got, input logic [4:0] exp_on);
`ifdef BCD_BLANK_EN
    check_eq(tag, {27'd0, got}, {27'd0, exp_on});
`else
    check_eq(tag, {27'd0, got}, 32'd0);
`endif
  endtask

  // One request on the round-robin instance, checked through to its done cycle
  task automatic run_one(input bit idx, input logic [15:0] val,
                         input logic [18:0] exp_bcd, input logic [4:0] exp_blank);
    bit bad;
    @(negedge clk);
    if (idx) begin req1 = 1'b1; bin1 = val; end
    else     begin req0 = 1'b1; bin0 = val; end
    @(negedge clk);
    check_eq("gnt", {30'd0, gnt1, gnt0}, idx ? 32'd2 : 32'd1);
    check_eq("busy_at_gnt", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    bad  = 1'b0;
    for (int k = 1; k < 17; k++) begin
      @(negedge clk);
      if (done || !busy || gnt0 || gnt1) bad = 1'b1;
    end
    check_eq("shift_window", {31'd0, bad}, 32'd0);
    @(negedge clk);
    check_eq("done", {31'd0, done}, 32'd1);
    check_eq("busy_in_done", {31'd0, busy}, 32'd0);
    check_eq("bcd", {13'd0, bcd}, {13'd0, exp_bcd});
    check_eq("done_id", {31'd0, done_id}, {31'd0, idx});
    check_blank("blank", blank, exp_blank);
  endtask

  initial begin
    int g0, g1;
    bit bad;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    f_req0 = 1'b0; f_req1 = 1'b0; f_bin0 = '0; f_bin1 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {24'd0, gnt0, gnt1, busy, done, done_id, blank[2:0]}, 32'd0);
    check_eq("rst_bcd", {13'd0, bcd}, 32'd0);
    check_eq("rst_fp_outputs", {27'd0, f_gnt0, f_gnt1, f_busy, f_done, f_done_id}, 32'd0);
    rst_n = 1'b1;

    run_one(1'b0, 16'd0, 19'h00000, 5'b11110);
    run_one(1'b1, 16'd65535, 19'h65535, 5'b00000);

    repeat (3) @(negedge clk);
    check_eq("hold_bcd", {13'd0, bcd}, 32'h65535);
    check_eq("hold_id_done", {30'd0, done_id, done}, 32'd2);

    // Both requesters held; pointer is reset so requester 0 goes first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bin0 = 16'd1234; bin1 = 16'd9999; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check_eq("rr_first_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0;
    g1 = 0;
    for (int k = 1; k < 17; k++) begin
      @(negedge clk);
      if (gnt1) g1++;
    end
    check_eq("no_gnt_while_busy", g1, 32'd0);
    @(negedge clk);
    check_eq("rr_done0", {31'd0, done}, 32'd1);
    check_eq("rr_bcd0", {13'd0, bcd}, 32'h01234);
    check_eq("rr_id0", {31'd0, done_id}, 32'd0);
    check_blank("rr_blank0", blank, 5'b10000);
    check_eq("rr_gnt_in_done", {30'd0, gnt1, gnt0}, 32'd0);
    @(negedge clk);
    check_eq("rr_b2b_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
    req1 = 1'b0;
    repeat (16) @(negedge clk);
    @(negedge clk);
    check_eq("rr_done1", {31'd0, done}, 32'd1);
    check_eq("rr_bcd1", {13'd0, bcd}, 32'h09999);
    check_eq("rr_id1", {31'd0, done_id}, 32'd1);

    // Fixed priority: requester 1 must never be served
    @(negedge clk);
    f_bin0 = 16'd77; f_bin1 = 16'd88; f_req0 = 1'b1; f_req1 = 1'b1;
    g0 = 0; g1 = 0;
    for (int k = 1; k <= 54; k++) begin
      @(negedge clk);
      if (f_gnt0) g0++;
      if (f_gnt1) g1++;
    end
    f_req0 = 1'b0; f_req1 = 1'b0;
    check_eq("fp_gnt0_count", g0, 32'd3);
    check_eq("fp_gnt1_count", g1, 32'd0);
    check_eq("fp_done", {31'd0, f_done}, 32'd1);
    check_eq("fp_bcd", {13'd0, f_bcd}, 32'h00077);
    check_eq("fp_id", {31'd0, f_done_id}, 32'd0);

    // Reset in the middle of the shift phase
    @(negedge clk);
    req0 = 1'b1; bin0 = 16'd500;
    @(negedge clk);
    check_eq("abort_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_outputs", {24'd0, gnt0, gnt1, busy, done, done_id, blank[2:0]}, 32'd0);
    check_eq("abort_bcd", {13'd0, bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    check_eq("abort_no_done", {31'd0, bad}, 32'd0);
    run_one(1'b0, 16'd500, 19'h00500, 5'b11000);
    run_one(1'b1, 16'd42, 19'h00042, 5'b11100);
    run_one(1'b0, 16'd0, 19'h00000, 5'b11110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
